victim_select_controller: RTL and testbench
===========================================

VICTIM_SELECT_CONTROLLER -- requirements
Module: victim_select_controller

Interface
REQ-001 Parameter: NUMBER_OF_CACHE_LINES, default 4, number of cache lines managed.
REQ-002 Parameter: COUNTER_WIDTH, default 2 for <=4 lines, 3/4/5/6/7 for <=8/16/32/64/128, else 8; line-index width.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 accessValid  in  1  hit on accessLine this cycle.
REQ-006 accessLine  in  COUNTER_WIDTH  line index of the hit.
REQ-007 allocateRequest  in  1  requester needs a line; held until allocateGrant.
REQ-008 allocateGrant  out  1  one-cycle pulse; allocateLine is valid.
REQ-009 allocateLine  out  COUNTER_WIDTH  selected victim line.
REQ-010 validVector  in  NUMBER_OF_CACHE_LINES  per-line valid bits.
REQ-011 dirtyVector  in  NUMBER_OF_CACHE_LINES  per-line dirty bits.
REQ-012 writeBackRequest  out  1  victim needs write-back; held until writeBackDone.
REQ-013 writeBackLine  out  COUNTER_WIDTH  line to write back.
REQ-014 writeBackDone  in  1  one-cycle completion pulse.
REQ-015 lastAccessedCacheLine  out  COUNTER_WIDTH  update index to replacement algorithm.
REQ-016 algorithmEnable  out  1  replacement-algorithm update strobe.
REQ-017 algorithmReset  out  1  replacement-algorithm reset.
REQ-018 replacementCacheLine  in  COUNTER_WIDTH  algorithm's current victim candidate.

Function
REQ-019 FSM states: IDLE, SELECT, WRITE_BACK, GRANT.
REQ-020 IDLE: allocateRequest=1 -> SELECT next cycle.
REQ-021 IDLE/SELECT/WRITE_BACK: algorithmEnable=accessValid, lastAccessedCacheLine=accessLine, combinational, zero latency.
REQ-022 SELECT: victim registered: lowest-index line with validVector=0 if any, else replacementCacheLine.
REQ-023 SELECT: victim valid and dirty -> WRITE_BACK; otherwise -> GRANT.
REQ-024 WRITE_BACK: writeBackRequest=1, writeBackLine=victim; on writeBackDone -> GRANT; writeBackRequest low from the GRANT cycle.
REQ-025 GRANT: allocateGrant=1, allocateLine=victim, algorithmEnable=1, lastAccessedCacheLine=victim; -> IDLE.
REQ-026 accessValid during GRANT is dropped; victim update has priority.
REQ-027 Back-to-back: allocateRequest still high in the IDLE cycle after GRANT starts a new allocation; minimum 3 cycles request-to-grant without write-back.
REQ-028 writeBackDone outside WRITE_BACK is ignored.
REQ-029 allocateRequest dropped before grant: FSM still completes the sequence; the grant pulse is still issued.

Reset
REQ-030 reset asserted: immediately state=IDLE, allocateGrant=0, writeBackRequest=0, victim register=0, allocateLine=0, writeBackLine=0.
REQ-031 algorithmReset is a register, 1 during reset and for the first clock edge after deassertion, then 0.
REQ-032 Reset mid-WRITE_BACK aborts the write-back; no grant is issued.

Configuration
REQ-033 Macro VICTIM_INVALID_FIRST_EN defined: invalid-line preference per REQ-022.
REQ-034 Macro undefined: victim is always replacementCacheLine; validVector only qualifies the dirty check.

Structure
REQ-035 Shared package victim_select_package: state enum type; COUNTER_WIDTH derivation function.
REQ-036 Sub-module invalid_line_finder: combinational lowest-index-zero priority encoder with found flag; instantiated only when VICTIM_INVALID_FIRST_EN is defined.

Verification
REQ-037 Reset release: algorithmReset=1 exactly one cycle; all other outputs 0.
REQ-038 validVector=4'b1011, allocateRequest -> allocateLine=2 in cycle 3, no write-back, algorithmEnable=1 and lastAccessedCacheLine=2 with grant.
REQ-039 All valid, dirtyVector=4'b0100, replacementCacheLine=2 -> writeBackRequest with line 2 until writeBackDone at cycle 7 -> grant line 2 at cycle 8.
REQ-040 accessValid=1, accessLine=3 in IDLE -> algorithmEnable=1, lastAccessedCacheLine=3 same cycle; repeat during GRANT -> lastAccessedCacheLine=victim.
REQ-041 reset pulsed during WRITE_BACK -> writeBackRequest=0 immediately, state IDLE, no allocateGrant.
REQ-042 Macro undefined, validVector=4'b0000, replacementCacheLine=1 -> allocateLine=1, no write-back.

Source files
------------

// File: rtl/victim_select_controller_pkg.sv
// victim_select_package
// Shared definitions for the victim-select controller slice:
//   stateType        - controller FSM state encoding
//   counterWidthFor  - line-index width for a given number of cache lines
//                      (2 bits up to 4 lines, then one bit per doubling,
//                      saturating at 8 bits above 128 lines)
package victim_select_package;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WRITE_BACK,
    GRANT
  } stateType;

  function automatic int counterWidthFor(input int numberOfLines);
    if (numberOfLines <= 4)        return 2;
    else if (numberOfLines <= 8)   return 3;
    else if (numberOfLines <= 16)  return 4;
    else if (numberOfLines <= 32)  return 5;
    else if (numberOfLines <= 64)  return 6;
    else if (numberOfLines <= 128) return 7;
    else                           return 8;
  endfunction

endpackage

// File: rtl/victim_select_controller_finder.sv
// invalid_line_finder
// Combinational priority encoder returning the lowest-index cache line whose
// valid bit is clear. Only built when VICTIM_INVALID_FIRST_EN is defined.
// Ports:
//   validVector  in   per-line valid bits
//   found        out  at least one line is invalid
//   lineIndex    out  lowest invalid line index (0 when none is found)
module invalid_line_finder
  import victim_select_package::*;
#(
  parameter int NUMBER_OF_CACHE_LINES = 4,
  parameter int COUNTER_WIDTH         = counterWidthFor(NUMBER_OF_CACHE_LINES)
) (
  input  logic [NUMBER_OF_CACHE_LINES-1:0] validVector,
  output logic                             found,
  output logic [COUNTER_WIDTH-1:0]         lineIndex
);

  // Scanning from the top down lets each lower invalid line overwrite the
  // result, so the lowest index wins without a separate priority chain.
  always_comb begin
    found     = 1'b0;
    lineIndex = '0;
    for (int i = NUMBER_OF_CACHE_LINES - 1; i >= 0; i--) begin
      if (!validVector[i]) begin
        found     = 1'b1;
        lineIndex = COUNTER_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/victim_select_controller.sv
// victim_select_controller
// Picks a victim line for an allocation request, writes it back first when it
// holds valid dirty data, then grants it and tells the replacement algorithm
// that the victim has just been used.
// Optional feature: define VICTIM_INVALID_FIRST_EN to prefer the lowest-index
// invalid line over the replacement algorithm's candidate.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   accessValid/Line       cache hit notification
//   allocateRequest        held by the requester until allocateGrant
//   allocateGrant/Line     one-cycle grant pulse with the chosen line
//   validVector/dirtyVector per-line state bits
//   writeBackRequest/Line  held until writeBackDone pulses
//   writeBackDone          write-back completion pulse
//   lastAccessedCacheLine, algorithmEnable, algorithmReset
//                          update/reset port towards the replacement algorithm
//   replacementCacheLine   replacement algorithm's current victim candidate
module victim_select_controller
  import victim_select_package::*;
#(
  parameter int NUMBER_OF_CACHE_LINES = 4,
  parameter int COUNTER_WIDTH         = counterWidthFor(NUMBER_OF_CACHE_LINES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             accessValid,
  input  logic [COUNTER_WIDTH-1:0]         accessLine,
  input  logic                             allocateRequest,
  output logic                             allocateGrant,
  output logic [COUNTER_WIDTH-1:0]         allocateLine,
  input  logic [NUMBER_OF_CACHE_LINES-1:0] validVector,
  input  logic [NUMBER_OF_CACHE_LINES-1:0] dirtyVector,
  output logic                             writeBackRequest,
  output logic [COUNTER_WIDTH-1:0]         writeBackLine,
  input  logic                             writeBackDone,
  output logic [COUNTER_WIDTH-1:0]         lastAccessedCacheLine,
  output logic                             algorithmEnable,
  output logic                             algorithmReset,
  input  logic [COUNTER_WIDTH-1:0]         replacementCacheLine
);

  stateType                 state;
  logic [COUNTER_WIDTH-1:0] victim;
  logic [COUNTER_WIDTH-1:0] candidate;
  logic                     candidateNeedsWriteBack;

`ifdef VICTIM_INVALID_FIRST_EN
  logic                     invalidFound;
  logic [COUNTER_WIDTH-1:0] invalidLine;

  invalid_line_finder #(
    .NUMBER_OF_CACHE_LINES(NUMBER_OF_CACHE_LINES),
    .COUNTER_WIDTH        (COUNTER_WIDTH)
  ) invalidFinder (
    .validVector(validVector),
    .found      (invalidFound),
    .lineIndex  (invalidLine)
  );

  assign candidate = invalidFound ? invalidLine : replacementCacheLine;
`else
  assign candidate = replacementCacheLine;
`endif

  // An invalid line never holds data worth saving, so the dirty bit only
  // matters when the chosen line is also valid.
  assign candidateNeedsWriteBack = validVector[candidate] & dirtyVector[candidate];

  // Main controller FSM. The grant and write-back outputs are registered and
  // set on the transition into their state, so they line up exactly with
  // GRANT and WRITE_BACK. Reset drops everything at once, which also aborts
  // an in-flight write-back without producing a grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      victim           <= '0;
      allocateGrant    <= 1'b0;
      allocateLine     <= '0;
      writeBackRequest <= 1'b0;
      writeBackLine    <= '0;
    end else begin
      allocateGrant <= 1'b0;
      case (state)
        IDLE: begin
          if (allocateRequest) begin
            state <= SELECT;
          end
        end
        SELECT: begin
          victim <= candidate;
          if (candidateNeedsWriteBack) begin
            state            <= WRITE_BACK;
            writeBackRequest <= 1'b1;
            writeBackLine    <= candidate;
          end else begin
            state         <= GRANT;
            allocateGrant <= 1'b1;
            allocateLine  <= candidate;
          end
        end
        WRITE_BACK: begin
          if (writeBackDone) begin
            state            <= GRANT;
            writeBackRequest <= 1'b0;
            writeBackLine    <= '0;
            allocateGrant    <= 1'b1;
            allocateLine     <= victim;
          end
        end
        GRANT: begin
          state        <= IDLE;
          allocateLine <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The replacement algorithm is held in reset while we are, and released on
  // the first clock edge after our reset goes away.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      algorithmReset <= 1'b1;
    end else begin
      algorithmReset <= 1'b0;
    end
  end

  // Hits are forwarded to the algorithm with zero latency, except in GRANT
  // where the freshly allocated victim must be reported as most recently used;
  // a hit in that cycle is deliberately dropped.
  always_comb begin
    algorithmEnable       = accessValid;
    lastAccessedCacheLine = accessLine;
    if (state == GRANT) begin
      algorithmEnable       = 1'b1;
      lastAccessedCacheLine = victim;
    end
  end

endmodule

// File: tb/tb_victim_select_controller.sv
// tb_victim_select_controller
// Scoreboard bench for victim_select_controller. Each allocation pushes its
// expected victim (and expected write-back line) into queues; a monitor
// process pops them whenever the DUT presents a grant or starts a write-back.
// Expected values follow VICTIM_INVALID_FIRST_EN when it is defined.
module tb_victim_select_controller;

  localparam int LINES = 4;
  localparam int CW    = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            accessValid;
  logic [CW-1:0]   accessLine;
  logic            allocateRequest;
  logic            allocateGrant;
  logic [CW-1:0]   allocateLine;
  logic [LINES-1:0] validVector;
  logic [LINES-1:0] dirtyVector;
  logic            writeBackRequest;
  logic [CW-1:0]   writeBackLine;
  logic            writeBackDone;
  logic [CW-1:0]   lastAccessedCacheLine;
  logic            algorithmEnable;
  logic            algorithmReset;
  logic [CW-1:0]   replacementCacheLine;

  int checkCount = 0;
  int errorCount = 0;

  logic [CW-1:0] grantQ[$];
  logic [CW-1:0] wbQ[$];
  logic          prevWb;

  victim_select_controller #(
    .NUMBER_OF_CACHE_LINES(LINES),
    .COUNTER_WIDTH        (CW)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .accessValid          (accessValid),
    .accessLine           (accessLine),
    .allocateRequest      (allocateRequest),
    .allocateGrant        (allocateGrant),
    .allocateLine         (allocateLine),
    .validVector          (validVector),
    .dirtyVector          (dirtyVector),
    .writeBackRequest     (writeBackRequest),
    .writeBackLine        (writeBackLine),
    .writeBackDone        (writeBackDone),
    .lastAccessedCacheLine(lastAccessedCacheLine),
    .algorithmEnable      (algorithmEnable),
    .algorithmReset       (algorithmReset),
    .replacementCacheLine (replacementCacheLine)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts a write-back or
  // pulses a grant; anything the queues did not predict is an error.
  task automatic monitorLoop();
    logic [CW-1:0] e;
    prevWb = 1'b0;
    forever begin
      @(negedge clock);
      if (writeBackRequest && !prevWb) begin
        if (wbQ.size() == 0) begin
          checkOutput("unexpectedWriteBack", int'(writeBackRequest), 0);
        end else begin
          e = wbQ.pop_front();
          checkOutput("writeBackLine", int'(writeBackLine), int'(e));
        end
      end
      prevWb = writeBackRequest;
      if (allocateGrant) begin
        if (grantQ.size() == 0) begin
          checkOutput("unexpectedGrant", int'(allocateGrant), 0);
        end else begin
          e = grantQ.pop_front();
          checkOutput("allocateLine", int'(allocateLine), int'(e));
          checkOutput("grantLastAccessed", int'(lastAccessedCacheLine), int'(e));
          checkOutput("grantAlgorithmEnable", int'(algorithmEnable), 1);
          checkOutput("grantWriteBackLow", int'(writeBackRequest), 0);
        end
      end
    end
  endtask

  // One allocation: request in cycle 1, optional writeBackDone pulse in
  // doneCycle, and a check of request-to-grant latency and write-back length.
  task automatic applyStimulus(input string tag, input logic [LINES-1:0] valid,
                               input logic [LINES-1:0] dirty, input logic [CW-1:0] repl,
                               input logic [CW-1:0] expLine, input bit expWb,
                               input int expLatency, input int doneCycle,
                               input bit dropEarly, input bit keepRequest);
    int cyc;
    int wbCycles;
    bit granted;
    @(posedge clock);
    #1;
    validVector          = valid;
    dirtyVector          = dirty;
    replacementCacheLine = repl;
    allocateRequest      = 1'b1;
    writeBackDone        = (doneCycle == 1);
    grantQ.push_back(expLine);
    if (expWb) wbQ.push_back(expLine);
    cyc      = 1;
    wbCycles = 0;
    granted  = 1'b0;
    while (!granted && cyc <= 40) begin
      @(negedge clock);
      if (writeBackRequest) wbCycles++;
      if (allocateGrant) begin
        granted = 1'b1;
      end else begin
        @(posedge clock);
        #1;
        cyc++;
        writeBackDone = (cyc == doneCycle);
        if (dropEarly && cyc == 2) allocateRequest = 1'b0;
      end
    end
    if (!granted) checkOutput({tag, "GrantTimeout"}, int'(allocateGrant), 1);
    else checkOutput({tag, "Latency"}, cyc, expLatency);
    checkOutput({tag, "WriteBackCycles"}, wbCycles, expWb ? doneCycle - 2 : 0);
    if (!keepRequest) begin
      @(posedge clock);
      #1;
      allocateRequest = 1'b0;
      writeBackDone   = 1'b0;
    end
  endtask

  initial begin
    reset                = 1'b1;
    accessValid          = 1'b0;
    accessLine           = '0;
    allocateRequest      = 1'b0;
    validVector          = '0;
    dirtyVector          = '0;
    writeBackDone        = 1'b0;
    replacementCacheLine = '0;
    fork
      monitorLoop();
    join_none

    repeat (2) @(negedge clock);
    checkOutput("algResetDuringReset", int'(algorithmReset), 1);
    reset = 1'b0;
    #1;
    checkOutput("algResetAfterRelease", int'(algorithmReset), 1);
    checkOutput("resetGrant", int'(allocateGrant), 0);
    checkOutput("resetWbRequest", int'(writeBackRequest), 0);
    checkOutput("resetAllocateLine", int'(allocateLine), 0);
    checkOutput("resetWbLine", int'(writeBackLine), 0);
    checkOutput("resetAlgEnable", int'(algorithmEnable), 0);
    @(negedge clock);
    checkOutput("algResetCleared", int'(algorithmReset), 0);

    @(posedge clock);
    #1;
    accessValid = 1'b1;
    accessLine  = 2'd3;
    #1;
    checkOutput("idleAlgEnable", int'(algorithmEnable), 1);
    checkOutput("idleLastAccessed", int'(lastAccessedCacheLine), 3);

    applyStimulus("hitDuringGrant", 4'b1011, 4'b0000, 2'd2, 2'd2, 1'b0, 3, 1, 1'b0, 1'b0);
    accessValid = 1'b0;
    accessLine  = '0;
    #1;
    checkOutput("idleAlgDisabled", int'(algorithmEnable), 0);

`ifdef VICTIM_INVALID_FIRST_EN
    applyStimulus("invalidPref", 4'b1011, 4'b0100, 2'd0, 2'd2, 1'b0, 3, 0, 1'b0, 1'b0);
`else
    applyStimulus("invalidPref", 4'b1011, 4'b0100, 2'd0, 2'd0, 1'b0, 3, 0, 1'b0, 1'b0);
`endif
    applyStimulus("writeBack", 4'b1111, 4'b0100, 2'd2, 2'd2, 1'b1, 8, 7, 1'b0, 1'b0);
    applyStimulus("backToBackA", 4'b1111, 4'b0000, 2'd1, 2'd1, 1'b0, 3, 0, 1'b0, 1'b1);
    applyStimulus("backToBackB", 4'b1111, 4'b0000, 2'd3, 2'd3, 1'b0, 3, 0, 1'b0, 1'b0);
    applyStimulus("dropEarly", 4'b1111, 4'b0000, 2'd3, 2'd3, 1'b0, 3, 0, 1'b1, 1'b0);
`ifdef VICTIM_INVALID_FIRST_EN
    applyStimulus("allInvalid", 4'b0000, 4'b1111, 2'd1, 2'd0, 1'b0, 3, 0, 1'b0, 1'b0);
`else
    applyStimulus("allInvalid", 4'b0000, 4'b1111, 2'd1, 2'd1, 1'b0, 3, 0, 1'b0, 1'b0);
`endif
    applyStimulus("quickDone", 4'b1111, 4'b1000, 2'd3, 2'd3, 1'b1, 4, 3, 1'b0, 1'b0);

    @(posedge clock);
    #1;
    validVector          = 4'b1111;
    dirtyVector          = 4'b0001;
    replacementCacheLine = 2'd0;
    allocateRequest      = 1'b1;
    wbQ.push_back(2'd0);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("wbBeforeReset", int'(writeBackRequest), 1);
    reset = 1'b1;
    #1;
    checkOutput("midResetWbRequest", int'(writeBackRequest), 0);
    checkOutput("midResetGrant", int'(allocateGrant), 0);
    checkOutput("midResetAlgReset", int'(algorithmReset), 1);
    checkOutput("midResetWbLine", int'(writeBackLine), 0);
    allocateRequest = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("postResetAlgReset", int'(algorithmReset), 0);
    checkOutput("grantQueueEmpty", grantQ.size(), 0);
    checkOutput("wbQueueEmpty", wbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
